// File: rtl/fetch_pkg.sv
// Shared types and sizing for the matrix/vector operand fetch engine.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  localparam int FIFO_DEPTH = 2;
  localparam int TAG_W      = 2;

  // Payload packs {mat, vec, row_last, last}.
  function automatic int payload_w(input int data_size);
    return 2 * data_size + TAG_W;
  endfunction

endpackage

// File: rtl/fetch_skid_fifo.sv
// Two-entry registered FIFO between the RAM return path and the output stream.
module fetch_skid_fifo
  import fetch_pkg::*;
#(
  parameter int W = 34
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_clr,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_data,
  output logic [W-1:0] o_data,
  output logic [1:0]   o_count
);

  logic [W-1:0] r_mem [FIFO_DEPTH];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else if (i_clr) begin
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (i_pop) r_rd_ptr <= ~r_rd_ptr;
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/matvec_fetch_unit.sv
// Walks an NxN row-major matrix and N-entry vector in external RAM and streams
// (matrix, vector) operand pairs with row-end / matrix-end tags.
module matvec_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADD_SIZE  = 16,
  parameter int DATA_SIZE = 16,
  parameter int DIM_W     = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic                 i_flush,
  input  logic [ADD_SIZE-1:0]  i_mat_base,
  input  logic [ADD_SIZE-1:0]  i_vec_base,
  input  logic [DIM_W-1:0]     i_dim,
  output logic                 o_mem_rd_en,
  output logic [ADD_SIZE-1:0]  o_mem_mat_addr,
  output logic [ADD_SIZE-1:0]  o_mem_vec_addr,
  input  logic [DATA_SIZE-1:0] i_mem_mat_data,
  input  logic [DATA_SIZE-1:0] i_mem_vec_data,
  output logic                 o_out_valid,
  input  logic                 i_out_ready,
  output logic [DATA_SIZE-1:0] o_out_mat,
  output logic [DATA_SIZE-1:0] o_out_vec,
  output logic                 o_out_row_last,
  output logic                 o_out_last,
  output logic                 o_busy,
  output logic                 o_done
);

  localparam int PW = payload_w(DATA_SIZE);

  state_t              r_state, w_state_nxt;
  logic [DIM_W-1:0]    r_dim, r_row, r_col;
  logic [ADD_SIZE-1:0] r_vec_base, r_mat_ptr;
  logic                r_inflight, r_if_row_last, r_if_last;
  logic                r_done;

  logic                w_done_nxt, w_load;
  logic [DIM_W-1:0]    w_dim_m1;
  logic                w_row_last, w_last;
  logic                w_rd_en, w_pop, w_push;
  logic [1:0]          w_count;
  logic [2:0]          w_credit;
  logic                w_drained;
  logic [PW-1:0]       w_fifo_in, w_fifo_out;

  assign w_dim_m1   = r_dim - DIM_W'(1);
  assign w_row_last = (r_col == w_dim_m1);
  assign w_last     = w_row_last && (r_row == w_dim_m1);

  // Credit counts FIFO entries plus the read in flight, net of this cycle's pop,
  // so the 2-entry FIFO can never overflow.
  assign w_pop     = o_out_valid && i_out_ready;
  assign w_credit  = {1'b0, w_count} + {2'b00, r_inflight} - {2'b00, w_pop};
  assign w_rd_en   = (r_state == S_RUN) && !i_flush && (w_credit < 3'd2);
  assign w_push    = r_inflight && !i_flush;
  assign w_drained = !r_inflight && ((w_count == 2'd0) || ((w_count == 2'd1) && w_pop));

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (i_start) begin
          w_load = 1'b1;
          if (i_dim == '0) w_done_nxt  = 1'b1;
          else             w_state_nxt = S_RUN;
        end
      end
      S_RUN:   if (w_rd_en && w_last) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (w_drained) begin
          w_state_nxt = S_IDLE;
          w_done_nxt  = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (i_flush) begin
      w_state_nxt = S_IDLE;
      w_done_nxt  = 1'b0;
      w_load      = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_dim         <= '0;
      r_vec_base    <= '0;
      r_mat_ptr     <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_inflight    <= 1'b0;
      r_if_row_last <= 1'b0;
      r_if_last     <= 1'b0;
    end else if (i_flush) begin
      r_mat_ptr     <= '0;
      r_row         <= '0;
      r_col         <= '0;
      r_inflight    <= 1'b0;
      r_if_row_last <= 1'b0;
      r_if_last     <= 1'b0;
    end else begin
      r_inflight <= w_rd_en;
      if (w_rd_en) begin
        r_if_row_last <= w_row_last;
        r_if_last     <= w_last;
      end
      if (w_load) begin
        r_dim      <= i_dim;
        r_vec_base <= i_vec_base;
        r_mat_ptr  <= i_mat_base;
        r_row      <= '0;
        r_col      <= '0;
      end else if (w_rd_en) begin
        r_mat_ptr <= r_mat_ptr + ADD_SIZE'(1);
        if (w_row_last) begin
          r_col <= '0;
          r_row <= r_row + DIM_W'(1);
        end else begin
          r_col <= r_col + DIM_W'(1);
        end
      end
    end
  end

  assign w_fifo_in = {i_mem_mat_data, i_mem_vec_data, r_if_row_last, r_if_last};

  fetch_skid_fifo #(.W(PW)) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_clr   (i_flush),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_data  (w_fifo_in),
    .o_data  (w_fifo_out),
    .o_count (w_count)
  );

  assign o_mem_rd_en    = w_rd_en;
  assign o_mem_mat_addr = r_mat_ptr;
  assign o_mem_vec_addr = r_vec_base + ADD_SIZE'(r_col);
  assign o_out_valid    = (w_count != 2'd0);
  assign o_out_mat      = w_fifo_out[PW-1 -: DATA_SIZE];
  assign o_out_vec      = w_fifo_out[TAG_W +: DATA_SIZE];
  assign o_out_row_last = w_fifo_out[1];
  assign o_out_last     = w_fifo_out[0];
  assign o_busy         = (r_state != S_IDLE);
  assign o_done         = r_done;

endmodule

// File: tb/tb_matvec_fetch_unit.sv
// Directed self-checking bench for matvec_fetch_unit with a 1-cycle-latency RAM model.
module tb_matvec_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n, start, flush, ready;
  logic [15:0] mat_base, vec_base;
  logic [7:0]  dim;
  logic        rd_en, valid, row_last, last_t, busy, done;
  logic [15:0] mat_addr, vec_addr, mat_data, vec_data, out_mat, out_vec;

  int total = 0;
  int bad   = 0;

  int          cyc, n_iss, n_pop, max_out, done_cnt, done_cyc, busy_cnt, valid_cnt;
  int          first_valid, unstable;
  logic        prev_hold;
  logic [33:0] prev_out;
  logic [15:0] qma[$], qva[$];
  logic [33:0] qp[$];
  int          qc[$];

  always #5 clk = ~clk;

  matvec_fetch_unit dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_start        (start),
    .i_flush        (flush),
    .i_mat_base     (mat_base),
    .i_vec_base     (vec_base),
    .i_dim          (dim),
    .o_mem_rd_en    (rd_en),
    .o_mem_mat_addr (mat_addr),
    .o_mem_vec_addr (vec_addr),
    .i_mem_mat_data (mat_data),
    .i_mem_vec_data (vec_data),
    .o_out_valid    (valid),
    .i_out_ready    (ready),
    .o_out_mat      (out_mat),
    .o_out_vec      (out_vec),
    .o_out_row_last (row_last),
    .o_out_last     (last_t),
    .o_busy         (busy),
    .o_done         (done)
  );

  function automatic logic [15:0] mval(input logic [15:0] a);
    return a ^ 16'h5A00;
  endfunction

  function automatic logic [15:0] vval(input logic [15:0] a);
    return a + 16'h0300;
  endfunction

  function automatic logic [33:0] exp_pair(input int k, input int n,
                                           input logic [15:0] mb, input logic [15:0] vb);
    int c;
    c = k % n;
    return {mval(mb + 16'(k)), vval(vb + 16'(c)), (c == n - 1), (k == n * n - 1)};
  endfunction

  always @(posedge clk) begin
    if (rd_en) begin
      mat_data <= mval(mat_addr);
      vec_data <= vval(vec_addr);
    end
  end

  task automatic clear_logs();
    cyc = 0; n_iss = 0; n_pop = 0; max_out = 0; done_cnt = 0; done_cyc = -1;
    busy_cnt = 0; valid_cnt = 0; first_valid = -1; unstable = 0; prev_hold = 1'b0;
    prev_out = '0;
    qma.delete(); qva.delete(); qp.delete(); qc.delete();
  endtask

  // rmode: 0 ready low, 1 ready high, 2 toggling 1010 starting high
  task automatic run_cycles(input int ncyc, input int rmode, input bit stop_on_done,
                            input int start_at, input int flush_at);
    logic [33:0] cur;
    for (int j = 0; j < ncyc; j++) begin
      @(negedge clk);
      cyc++;
      start = (cyc == start_at);
      flush = (cyc == flush_at);
      case (rmode)
        0:       ready = 1'b0;
        1:       ready = 1'b1;
        default: ready = (cyc % 2 == 1);
      endcase
      #1;
      cur = {out_mat, out_vec, row_last, last_t};
      if (prev_hold && cur !== prev_out) unstable++;
      prev_hold = valid && !ready;
      prev_out  = cur;
      if (rd_en) begin qma.push_back(mat_addr); qva.push_back(vec_addr); n_iss++; end
      if (valid) begin
        valid_cnt++;
        if (first_valid < 0) first_valid = cyc;
      end
      if (valid && ready) begin qp.push_back(cur); qc.push_back(cyc); n_pop++; end
      if (n_iss - n_pop > max_out) max_out = n_iss - n_pop;
      if (busy) busy_cnt++;
      if (done) begin done_cnt++; done_cyc = cyc; end
      if (stop_on_done && done) break;
    end
  endtask

  task automatic kick(input logic [7:0] n, input logic [15:0] mb, input logic [15:0] vb);
    clear_logs();
    @(negedge clk);
    start = 1'b1; dim = n; mat_base = mb; vec_base = vb; flush = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; ready = 1'b1;
    dim = '0; mat_base = '0; vec_base = '0;
    #1;
    total++;
    if ({rd_en, mat_addr, vec_addr, valid, out_mat, out_vec, row_last, last_t, busy, done} !== '0) begin
      $display("FAIL reset_outputs: got rd=%b ma=%h va=%h v=%b m=%h d=%h busy=%b done=%b, want all 0",
               rd_en, mat_addr, vec_addr, valid, out_mat, out_vec, busy, done);
      bad++;
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    logic [15:0] ema [4];
    logic [15:0] eva [4];
    ema = '{16'h0000, 16'h0001, 16'h0002, 16'h0003};
    eva = '{16'h0005, 16'h0006, 16'h0005, 16'h0006};
    kick(8'd2, 16'h0000, 16'h0005);
    run_cycles(20, 1, 1'b1, 0, 0);
    total++;
    if (n_iss != 4) begin $display("FAIL basic_issue_count: got %0d want 4", n_iss); bad++; end
    for (int k = 0; k < 4 && k < qma.size(); k++) begin
      total++;
      if (qma[k] !== ema[k] || qva[k] !== eva[k]) begin
        $display("FAIL basic_addr%0d: got %h/%h want %h/%h", k, qma[k], qva[k], ema[k], eva[k]);
        bad++;
      end
    end
    total++;
    if (qp.size() != 4) begin $display("FAIL basic_pairs: got %0d want 4", qp.size()); bad++; end
    for (int k = 0; k < 4 && k < qp.size(); k++) begin
      total++;
      if (qp[k] !== exp_pair(k, 2, 16'h0000, 16'h0005) || qc[k] != k + 3) begin
        $display("FAIL basic_pair%0d: got %h @%0d want %h @%0d", k, qp[k], qc[k],
                 exp_pair(k, 2, 16'h0000, 16'h0005), k + 3);
        bad++;
      end
    end
    total++;
    if (done_cyc != 7 || done_cnt != 1) begin
      $display("FAIL basic_done: got cycle %0d count %0d want cycle 7 count 1", done_cyc, done_cnt);
      bad++;
    end
    total++;
    if (busy !== 1'b0) begin $display("FAIL basic_busy_at_done: got %b want 0", busy); bad++; end
  endtask

  task automatic test_backpressure();
    kick(8'd3, 16'h0040, 16'h0010);
    run_cycles(60, 2, 1'b1, 0, 0);
    total++;
    if (qp.size() != 9) begin $display("FAIL bp_pairs: got %0d want 9", qp.size()); bad++; end
    for (int k = 0; k < 9 && k < qp.size(); k++) begin
      total++;
      if (qp[k] !== exp_pair(k, 3, 16'h0040, 16'h0010)) begin
        $display("FAIL bp_pair%0d: got %h want %h", k, qp[k], exp_pair(k, 3, 16'h0040, 16'h0010));
        bad++;
      end
    end
    total++;
    if (max_out > 2) begin $display("FAIL bp_credit: got outstanding %0d want <=2", max_out); bad++; end
    total++;
    if (unstable != 0) begin $display("FAIL bp_stable: got %0d changes want 0", unstable); bad++; end
    total++;
    if (done_cnt != 1) begin $display("FAIL bp_done: got %0d want 1", done_cnt); bad++; end
  endtask

  task automatic test_dim_zero();
    kick(8'd0, 16'h0100, 16'h0200);
    run_cycles(4, 1, 1'b0, 0, 0);
    total++;
    if (n_iss != 0 || busy_cnt != 0) begin
      $display("FAIL dim0_idle: got issues %0d busy %0d want 0 0", n_iss, busy_cnt);
      bad++;
    end
    total++;
    if (done_cnt != 1 || done_cyc != 1) begin
      $display("FAIL dim0_done: got count %0d cycle %0d want 1 1", done_cnt, done_cyc);
      bad++;
    end
  endtask

  task automatic test_wrap();
    logic [15:0] ema [4];
    ema = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    kick(8'd2, 16'hFFFE, 16'h0010);
    run_cycles(20, 1, 1'b1, 0, 0);
    total++;
    if (qma.size() != 4) begin $display("FAIL wrap_issues: got %0d want 4", qma.size()); bad++; end
    for (int k = 0; k < 4 && k < qma.size(); k++) begin
      total++;
      if (qma[k] !== ema[k]) begin
        $display("FAIL wrap_addr%0d: got %h want %h", k, qma[k], ema[k]);
        bad++;
      end
    end
    total++;
    if (qp.size() != 4 || qp[3] !== exp_pair(3, 2, 16'hFFFE, 16'h0010)) begin
      $display("FAIL wrap_last_pair: got %0d pairs want 4 ending %h", qp.size(),
               exp_pair(3, 2, 16'hFFFE, 16'h0010));
      bad++;
    end
  endtask

  task automatic test_flush_reset();
    kick(8'd4, 16'h0100, 16'h0040);
    run_cycles(7, 1, 1'b0, 0, 7);
    @(negedge clk);
    flush = 1'b0;
    #1;
    total++;
    if (valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      $display("FAIL flush_next: got valid=%b busy=%b done=%b want 0 0 0", valid, busy, done);
      bad++;
    end
    total++;
    if (done_cnt != 0) begin $display("FAIL flush_no_done_before: got %0d want 0", done_cnt); bad++; end
    clear_logs();
    run_cycles(6, 1, 1'b0, 0, 0);
    total++;
    if (done_cnt != 0 || valid_cnt != 0 || n_iss != 0) begin
      $display("FAIL flush_quiet: got done %0d valid %0d issues %0d want 0 0 0", done_cnt, valid_cnt, n_iss);
      bad++;
    end
    kick(8'd4, 16'h0100, 16'h0040);
    run_cycles(40, 1, 1'b1, 0, 0);
    total++;
    if (qp.size() != 16) begin $display("FAIL fresh_pairs: got %0d want 16", qp.size()); bad++; end
    for (int k = 0; k < 16 && k < qp.size(); k++) begin
      total++;
      if (qp[k] !== exp_pair(k, 4, 16'h0100, 16'h0040)) begin
        $display("FAIL fresh_pair%0d: got %h want %h", k, qp[k], exp_pair(k, 4, 16'h0100, 16'h0040));
        bad++;
      end
    end
    total++;
    if (done_cyc != 19) begin $display("FAIL fresh_done: got cycle %0d want 19", done_cyc); bad++; end
    kick(8'd4, 16'h0100, 16'h0040);
    run_cycles(6, 1, 1'b0, 0, 0);
    total++;
    if (valid !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL prereset_active: got valid=%b busy=%b want 1 1", valid, busy);
      bad++;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({rd_en, mat_addr, vec_addr, valid, out_mat, out_vec, row_last, last_t, busy, done} !== '0) begin
      $display("FAIL async_reset: got rd=%b ma=%h va=%h v=%b m=%h d=%h busy=%b, want all 0",
               rd_en, mat_addr, vec_addr, valid, out_mat, out_vec, busy);
      bad++;
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_back_to_back();
    kick(8'd2, 16'h0020, 16'h0030);
    run_cycles(1, 1, 1'b0, 0, 0);
    dim = 8'd3;
    run_cycles(20, 1, 1'b1, 2, 0);
    total++;
    if (qp.size() != 4 || done_cyc != 7) begin
      $display("FAIL b2b_ignore_start: got %0d pairs done@%0d want 4 done@7", qp.size(), done_cyc);
      bad++;
    end
    total++;
    if (qp.size() == 4 && qp[3] !== exp_pair(3, 2, 16'h0020, 16'h0030)) begin
      $display("FAIL b2b_first_last: got %h want %h", qp[3], exp_pair(3, 2, 16'h0020, 16'h0030));
      bad++;
    end
    start = 1'b1; dim = 8'd1; mat_base = 16'h0077; vec_base = 16'h0088;
    clear_logs();
    run_cycles(8, 1, 1'b0, 0, 0);
    total++;
    if (first_valid != 3) begin $display("FAIL b2b_latency: got %0d want 3", first_valid); bad++; end
    total++;
    if (qp.size() != 1 || qp[0] !== exp_pair(0, 1, 16'h0077, 16'h0088)) begin
      $display("FAIL b2b_pair: got %0d pairs want 1 of %h", qp.size(), exp_pair(0, 1, 16'h0077, 16'h0088));
      bad++;
    end
    total++;
    if (done_cyc != 4 || done_cnt != 1) begin
      $display("FAIL b2b_done: got cycle %0d count %0d want 4 1", done_cyc, done_cnt);
      bad++;
    end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_basic();
    test_backpressure();
    test_dim_zero();
    test_wrap();
    test_flush_reset();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
